// File: rtl/mult_sched_if.sv
// rtl/mult_sched_if.sv - operand issue and block readback bus between mult_sched and the multiplier
`timescale 1ns/1ps
interface mult_sched_if;
  logic        RDY_mult;
  logic        EN_mult;
  logic [15:0] mult_input0;
  logic [15:0] mult_input1;
  logic        EN_blockRead;
  logic        VALID_memVal;
  logic [31:0] memVal_data;

  modport master (
    input  RDY_mult,
    input  VALID_memVal,
    input  memVal_data,
    output EN_mult,
    output mult_input0,
    output mult_input1,
    output EN_blockRead
  );

  modport slave (
    output RDY_mult,
    output VALID_memVal,
    output memVal_data,
    input  EN_mult,
    input  mult_input0,
    input  mult_input1,
    input  EN_blockRead
  );
endinterface

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - two-requester round-robin scheduler feeding a multiplier with
// BLOCK_LEN operand pairs per job and forwarding the read-back results
`timescale 1ns/1ps
module mult_sched #(
  parameter int BLOCK_LEN = 64,
  parameter int TIMEOUT   = 256
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [15:0]  op_a0,
  input  logic [15:0]  op_a1,
  input  logic [15:0]  op_b0,
  input  logic [15:0]  op_b1,
  output logic [1:0]   grant,
  mult_sched_if.master mbus,
  output logic         res_valid,
  output logic         res_id,
  output logic [31:0]  res_data,
  output logic [1:0]   done,
  output logic         err,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, DRAIN, DONE} state_t;

  localparam int CW = $clog2(BLOCK_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(BLOCK_LEN - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] n;
  logic [CW-1:0] rcnt;
  logic [TW-1:0] tcnt;
  logic [15:0]   a_q;
  logic [15:0]   b_q;
  logic          owner;
  logic          last_owner;
  logic          pick;
  logic          issue_beat;
  logic          issue_last;
  logic          drain_last;
  logic          timeout_hit;

  // On a tie the requester that did not own the previous job wins.
  always_comb begin
    pick        = (req == 2'b11) ? ~last_owner : req[1];
    issue_beat  = (state == ISSUE) && mbus.RDY_mult;
    issue_last  = issue_beat && (n == LAST_IDX);
    drain_last  = (state == DRAIN) && mbus.VALID_memVal && (rcnt == LAST_IDX);
    timeout_hit = (state == WAIT_RD) && !mbus.VALID_memVal && (tcnt == LAST_TICK);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx          = state;
    mbus.EN_mult      = 1'b0;
    mbus.EN_blockRead = 1'b0;
    done              = 2'b00;
    busy              = (state != IDLE);
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        mbus.EN_mult = issue_beat;
        if (issue_last) begin
          state_nx = WAIT_RD;
        end
      end
      WAIT_RD: begin
        mbus.EN_blockRead = 1'b1;
        if (mbus.VALID_memVal) begin
          state_nx = DRAIN;
        end else if (timeout_hit) begin
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = owner ? 2'b10 : 2'b01;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operands are held in registers so the bus keeps its last value outside ISSUE.
  assign mbus.mult_input0 = a_q;
  assign mbus.mult_input1 = b_q + 16'(n);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      grant      <= 2'b00;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      n          <= '0;
      rcnt       <= '0;
      tcnt       <= '0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_data   <= '0;
      err        <= 1'b0;
    end else begin
      grant     <= 2'b00;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            grant <= pick ? 2'b10 : 2'b01;
            owner <= pick;
            a_q   <= pick ? op_a1 : op_a0;
            b_q   <= pick ? op_b1 : op_b0;
            n     <= '0;
          end
        end
        ISSUE: begin
          if (issue_beat) begin
            if (issue_last) begin
              tcnt <= '0;
            end else begin
              n <= n + CW'(1);
            end
          end
        end
        WAIT_RD: begin
          if (mbus.VALID_memVal) begin
            res_valid <= 1'b1;
            res_id    <= owner;
            res_data  <= mbus.memVal_data;
            rcnt      <= CW'(1);
          end else if (timeout_hit) begin
            err        <= 1'b1;
            last_owner <= owner;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DRAIN: begin
          if (mbus.VALID_memVal) begin
            res_valid <= 1'b1;
            res_id    <= owner;
            res_data  <= mbus.memVal_data;
            rcnt      <= rcnt + CW'(1);
          end
        end
        DONE: begin
          last_owner <= owner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - self-checking bench for mult_sched against a job-level model
`timescale 1ns/1ps
module tb_mult_sched;
  localparam int BL = 64;
  localparam int TO = 256;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [15:0] op_a0 = '0;
  logic [15:0] op_a1 = '0;
  logic [15:0] op_b0 = '0;
  logic [15:0] op_b1 = '0;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        res_valid;
  logic        res_id;
  logic        err;
  logic        busy;
  logic [31:0] res_data;

  mult_sched_if mbus ();

  mult_sched #(.BLOCK_LEN(BL), .TIMEOUT(TO)) dut (
    .CLK(CLK), .rst(rst), .req(req),
    .op_a0(op_a0), .op_a1(op_a1), .op_b0(op_b0), .op_b1(op_b1),
    .grant(grant), .mbus(mbus),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .done(done), .err(err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // job-level model
  bit          job_active;
  bit          last_m = 1'b1;
  bit          owner_m;
  bit          err_m;
  bit          first_taken;
  logic [15:0] ea;
  logic [15:0] eb;
  int          issued;
  int          res_cnt;
  int          wait_cyc;
  int          done_cnt;
  logic [1:0]  grant_log[$];
  logic [31:0] res_log[$];
  logic [15:0] in1_log[$];

  bit          bp_mode;
  bit          mem_mute;
  int          stall;
  logic [31:0] prod_q[$];

  task automatic ck(input bit ok, input string nm, input longint act, input longint expv);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic bit outs_zero();
    return grant == 2'b00 && done == 2'b00 && !busy && !err && !res_valid && !res_id
        && res_data == '0 && !mbus.EN_mult && !mbus.EN_blockRead
        && mbus.mult_input0 == '0 && mbus.mult_input1 == '0;
  endfunction

  function automatic logic [1:0] oh(input bit o);
    return o ? 2'b10 : 2'b01;
  endfunction

  always @(negedge CLK) begin : compare
    bit          in_issue;
    bit          exp_blk;
    bit          exp_done;
    logic [15:0] bb;
    logic [31:0] er;
    if (rst) begin
      ck(outs_zero(), "reset_outputs", longint'({grant, done, busy, err, res_valid}), 0);
      job_active  = 0;
      last_m      = 1;
      err_m       = 0;
      issued      = 0;
      res_cnt     = 0;
      wait_cyc    = 0;
      first_taken = 0;
    end else begin
      if (grant != 2'b00) begin
        ck(!job_active, "grant_during_job", longint'(grant), 0);
        owner_m = (req == 2'b11) ? ~last_m : req[1];
        ck(grant == oh(owner_m), "grant", longint'(grant), longint'(oh(owner_m)));
        ea          = owner_m ? op_a1 : op_a0;
        eb          = owner_m ? op_b1 : op_b0;
        job_active  = 1;
        issued      = 0;
        res_cnt     = 0;
        wait_cyc    = 0;
        first_taken = 0;
        grant_log.push_back(grant);
        res_log.delete();
        in1_log.delete();
      end
      ck(busy == job_active, "busy", longint'(busy), longint'(job_active));
      ck(err == err_m, "err", longint'(err), longint'(err_m));

      in_issue = job_active && issued < BL;
      exp_blk  = job_active && issued == BL && !first_taken && wait_cyc < TO;
      ck(mbus.EN_mult == (in_issue && mbus.RDY_mult), "en_mult",
         longint'(mbus.EN_mult), longint'(in_issue && mbus.RDY_mult));
      if (in_issue) begin
        ck(mbus.mult_input0 == ea, "mult_input0", longint'(mbus.mult_input0), longint'(ea));
        ck(mbus.mult_input1 == 16'(eb + 16'(issued)), "mult_input1",
           longint'(mbus.mult_input1), longint'(16'(eb + 16'(issued))));
        if (mbus.EN_mult) begin
          in1_log.push_back(mbus.mult_input1);
          issued++;
        end
      end
      ck(mbus.EN_blockRead == exp_blk, "en_blockread", longint'(mbus.EN_blockRead), longint'(exp_blk));
      if (exp_blk) begin
        if (mbus.VALID_memVal) begin
          first_taken = 1;
        end else begin
          wait_cyc++;
          if (wait_cyc == TO) begin
            err_m      = 1;
            job_active = 0;
            last_m     = owner_m;
          end
        end
      end

      if (res_valid) begin
        bb = eb + 16'(res_cnt);
        er = {16'h0, ea} * {16'h0, bb};
        ck(job_active && res_cnt < BL, "res_beat_in_job", longint'(res_cnt), BL);
        ck(res_id == owner_m, "res_id", longint'(res_id), longint'(owner_m));
        ck(res_data == er, "res_data", longint'(res_data), longint'(er));
        res_log.push_back(res_data);
        res_cnt++;
      end
      exp_done = job_active && res_cnt == BL;
      ck(done == (exp_done ? oh(owner_m) : 2'b00), "done",
         longint'(done), longint'(exp_done ? oh(owner_m) : 2'b00));
      if (exp_done) begin
        job_active = 0;
        last_m     = owner_m;
        done_cnt++;
      end
    end
  end

  // Multiplier stand-in: records issued pairs, streams products back with gaps plus two surplus beats.
  initial begin : stub
    int gap;
    int extra;
    bit streaming;
    mbus.RDY_mult     = 1'b1;
    mbus.VALID_memVal = 1'b0;
    mbus.memVal_data  = '0;
    gap       = 0;
    extra     = 0;
    streaming = 0;
    stall     = 0;
    forever begin
      @(negedge CLK);
      if (rst) begin
        prod_q.delete();
        streaming = 0;
        extra     = 0;
      end else begin
        if (grant != 2'b00) begin
          prod_q.delete();
          streaming = 0;
          extra     = 0;
          gap       = 0;
        end
        if (mbus.EN_mult) prod_q.push_back({16'h0, mbus.mult_input0} * {16'h0, mbus.mult_input1});
      end
      @(posedge CLK);
      #1;
      mbus.VALID_memVal = 1'b0;
      mbus.RDY_mult     = 1'b1;
      if (!bp_mode) stall = 0;
      if (!rst) begin
        if (bp_mode && issued == 10 && stall < 5) begin
          mbus.RDY_mult = 1'b0;
          stall++;
        end
        if (!mem_mute && (mbus.EN_blockRead || streaming)) begin
          streaming = 1;
          gap++;
          if (prod_q.size() > 0) begin
            if (gap % 7 != 3) begin
              mbus.VALID_memVal = 1'b1;
              mbus.memVal_data  = prod_q.pop_front();
            end
          end else if (extra < 2) begin
            mbus.VALID_memVal = 1'b1;
            mbus.memVal_data  = 32'hDEAD_BEEF;
            extra++;
          end else begin
            streaming = 0;
          end
        end
      end else begin
        streaming = 0;
      end
    end
  end

  task automatic start_req(input logic [1:0] r, input string nm);
    int base;
    int i;
    base = grant_log.size();
    req  = r;
    i    = 0;
    while (grant_log.size() == base && i < 20) begin
      @(negedge CLK);
      #1;
      i++;
    end
    ck(grant_log.size() > base, nm, grant_log.size(), base + 1);
    req = 2'b00;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    i = 0;
    while (job_active && i < budget) begin
      @(negedge CLK);
      #1;
      i++;
    end
    ck(!job_active, nm, longint'(job_active), 0);
  endtask

  initial begin : main
    int base;
    int d0;
    int i;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;

    // single job, owner 0, products 6*n
    op_a0 = 16'd6;
    op_b0 = 16'd0;
    start_req(2'b01, "single_grant_seen");
    wait_idle(400, "single_job_end");
    ck(res_log.size() == BL, "single_res_count", res_log.size(), BL);
    ck(done_cnt == 1, "single_done_count", done_cnt, 1);
    if (res_log.size() == BL && in1_log.size() == BL) begin
      ck(res_log[1] == 32'd6, "single_res1", longint'(res_log[1]), 6);
      ck(res_log[63] == 32'd378, "single_res63", longint'(res_log[63]), 378);
      ck(in1_log[63] == 16'd63, "single_in1_63", longint'(in1_log[63]), 63);
    end

    // contention from reset: 01, 10, 01
    rst = 1'b1;
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    op_a0 = 16'd3;
    op_b0 = 16'd100;
    op_a1 = 16'd5;
    op_b1 = 16'd7;
    base = grant_log.size();
    d0   = done_cnt;
    req  = 2'b11;
    i    = 0;
    while (grant_log.size() < base + 3 && i < 2000) begin
      @(negedge CLK);
      #1;
      i++;
    end
    req = 2'b00;
    ck(grant_log.size() == base + 3, "contention_grant_count", grant_log.size(), base + 3);
    wait_idle(400, "contention_end");
    ck(done_cnt == d0 + 3, "contention_done_count", done_cnt, d0 + 3);
    if (grant_log.size() == base + 3) begin
      ck(grant_log[base] == 2'b01, "contention_g0", longint'(grant_log[base]), 1);
      ck(grant_log[base + 1] == 2'b10, "contention_g1", longint'(grant_log[base + 1]), 2);
      ck(grant_log[base + 2] == 2'b01, "contention_g2", longint'(grant_log[base + 2]), 1);
    end
    if (res_log.size() == BL)
      ck(res_log[63] == 32'd489, "contention_last_res", longint'(res_log[63]), 489);

    // backpressure at n = 10 for five cycles
    bp_mode = 1;
    op_a0 = 16'h0012;
    op_b0 = 16'h0100;
    start_req(2'b01, "bp_grant_seen");
    wait_idle(400, "bp_end");
    ck(stall == 5, "bp_stall_cycles", stall, 5);
    bp_mode = 0;
    ck(in1_log.size() == BL, "bp_beat_count", in1_log.size(), BL);
    if (in1_log.size() == BL && res_log.size() == BL) begin
      ck(in1_log[10] == 16'h010A, "bp_in1_10", longint'(in1_log[10]), 16'h010A);
      ck(res_log[12] == 32'd4824, "bp_res12", longint'(res_log[12]), 4824);
    end

    // operand wrap on requester 1
    op_a1 = 16'd2;
    op_b1 = 16'hFFF0;
    start_req(2'b10, "wrap_grant_seen");
    wait_idle(400, "wrap_end");
    if (in1_log.size() == BL && res_log.size() == BL) begin
      ck(in1_log[15] == 16'hFFFF, "wrap_in1_15", longint'(in1_log[15]), 16'hFFFF);
      ck(in1_log[16] == 16'h0000, "wrap_in1_16", longint'(in1_log[16]), 0);
      ck(res_log[15] == 32'h0001_FFFE, "wrap_res15", longint'(res_log[15]), 32'h1FFFE);
      ck(res_log[16] == 32'd0, "wrap_res16", longint'(res_log[16]), 0);
      ck(res_log[17] == 32'd2, "wrap_res17", longint'(res_log[17]), 2);
    end

    // readback timeout, then a normal job
    mem_mute = 1;
    op_a0 = 16'd1;
    op_b0 = 16'd1;
    d0 = done_cnt;
    start_req(2'b01, "to_grant_seen");
    wait_idle(600, "to_end");
    mem_mute = 0;
    @(negedge CLK);
    #1;
    ck(err == 1'b1, "to_err", longint'(err), 1);
    ck(busy == 1'b0, "to_busy", longint'(busy), 0);
    ck(done_cnt == d0, "to_no_done", done_cnt, d0);
    op_a1 = 16'd7;
    op_b1 = 16'd9;
    start_req(2'b10, "after_to_grant_seen");
    wait_idle(400, "after_to_end");
    ck(done_cnt == d0 + 1, "after_to_done", done_cnt, d0 + 1);
    if (res_log.size() == BL)
      ck(res_log[0] == 32'd63, "after_to_res0", longint'(res_log[0]), 63);

    // reset in the middle of DRAIN
    op_a0 = 16'd9;
    op_b0 = 16'd3;
    start_req(2'b01, "mid_grant_seen");
    i = 0;
    while (res_cnt < 20 && i < 400) begin
      @(negedge CLK);
      #1;
      i++;
    end
    ck(res_cnt >= 20, "mid_reach_drain", res_cnt, 20);
    @(posedge CLK);
    #2 rst = 1'b1;
    #1;
    ck(outs_zero(), "mid_reset_outputs", longint'({grant, done, busy, err, res_valid}), 0);
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    op_a1 = 16'd4;
    op_b1 = 16'd5;
    d0 = done_cnt;
    start_req(2'b10, "post_reset_grant_seen");
    wait_idle(400, "post_reset_end");
    ck(done_cnt == d0 + 1, "post_reset_done", done_cnt, d0 + 1);
    ck(grant_log[$] == 2'b10, "post_reset_grant", longint'(grant_log[$]), 2);
    if (res_log.size() == BL)
      ck(res_log[63] == 32'd272, "post_reset_res63", longint'(res_log[63]), 272);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001: Parameter BLOCK_LEN, default 64, number of products per job (2..64).
REQ-002: Parameter TIMEOUT, default 256, maximum cycles in WAIT_RD before abort.
REQ-003: Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004: CLK  input  1  rising-edge clock.
REQ-005: rst  input  1  asynchronous active-high reset.
REQ-006: req  input  2  per-requester job request, held until the matching grant bit pulses.
REQ-007: op_a0, op_a1  input  16 each  fixed operand of requester 0/1.
REQ-008: op_b0, op_b1  input  16 each  base of the incrementing operand of requester 0/1.
REQ-009: grant  output  2  one-hot, one-cycle pulse when a job is accepted.
REQ-010: RDY_mult  input  1  multiplier can accept an operand pair this cycle.
REQ-011: EN_mult  output  1  operand pair on mult_input0/1 is valid this cycle.
REQ-012: mult_input0, mult_input1  output  16 each  operands to the multiplier.
REQ-013: EN_blockRead  output  1  request multiplier block readback.
REQ-014: VALID_memVal  input  1  memVal_data carries one result this cycle.
REQ-015: memVal_data  input  32  result word from the multiplier.
REQ-016: res_valid  output  1, res_id  output  1, res_data  output  32: forwarded result beat and its owner.
REQ-017: done  output  2  one-hot, one-cycle pulse at job completion.
REQ-018: err  output  1  sticky timeout flag, cleared only by reset.
REQ-019: busy  output  1  high in every state except IDLE.

Function
REQ-020: States are IDLE, ISSUE, WAIT_RD, DRAIN and DONE; no other state is reachable.
REQ-021: IDLE with any req bit set: arbitrate, pulse grant, latch operands, clear index n, go to ISSUE next cycle.
REQ-022: Arbitration is round-robin: a single requester wins; on simultaneous requests the requester not granted last wins.
REQ-023: ISSUE: EN_mult = RDY_mult; mult_input0 = latched op_a; mult_input1 = (latched op_b + n) mod 2^16.
REQ-024: ISSUE: n increments only on cycles with EN_mult high; RDY_mult low stalls n and holds the operand outputs.
REQ-025: ISSUE: after the beat with n = BLOCK_LEN-1, go to WAIT_RD; exactly BLOCK_LEN EN_mult beats are issued per job.
REQ-026: WAIT_RD: hold EN_blockRead high until the first VALID_memVal; EN_mult is low.
REQ-027: WAIT_RD: the first VALID_memVal beat counts as result 0; deassert EN_blockRead and go to DRAIN in the same edge.
REQ-028: DRAIN: each VALID_memVal beat registers res_valid = 1, res_data = memVal_data, res_id = owner, with 1-cycle latency.
REQ-029: DRAIN: after BLOCK_LEN beats go to DONE; VALID_memVal beats beyond BLOCK_LEN are ignored.
REQ-030: DONE lasts one cycle: pulse done[owner], update the round-robin pointer, return to IDLE.
REQ-031: A new grant occurs no earlier than the cycle after DONE.
REQ-032: WAIT_RD timeout: if TIMEOUT cycles pass without VALID_memVal, set err, drop EN_blockRead, return to IDLE with no done pulse, and update the pointer.
REQ-033: req changes during a job have no effect; the latched operands are used.
REQ-034: When not in ISSUE, EN_mult is 0 and mult_input0/1 hold their last value.

Reset
REQ-035: While rst is high, all outputs are 0 and the state is IDLE, from any state and mid-job, without waiting for a clock edge.
REQ-036: Reset sets the round-robin pointer so that requester 0 wins the first simultaneous request.
REQ-037: After rst deasserts, the first grant occurs no earlier than the first rising edge with req nonzero.

Verification
REQ-038: Single job: req=01, op_a0=6, op_b0=0, RDY_mult=1 -> grant=01; 64 EN_mult beats with mult_input1 = 0..63; one EN_blockRead pulse; 64 res beats of 6*n, res_id=0; done=01.
REQ-039: Contention: req=11 after reset, then held -> grant order 01, 10, 01; each done follows its grant.
REQ-040: Backpressure: RDY_mult low for cycles 10-14 of ISSUE -> n frozen at 10; still exactly 64 beats; products 10..14 correct.
REQ-041: Wrap: op_b1=0xFFF0, op_a1=2 -> mult_input1 wraps 0xFFFF to 0x0000; res_data for n=16 is 0.
REQ-042: Timeout: VALID_memVal held low -> after 256 WAIT_RD cycles err=1, no done, busy=0; the next request is still served.
REQ-043: Mid-job reset: assert rst in DRAIN after 20 beats -> all outputs 0 immediately; after release, req=10 is granted and completes normally.
